uart_param_regs: RTL and testbench

Byte-stream command parser and parameter register bank for the waveform generator. Sits between the UART wrapper's from/to byte streams and the NCO/amplitude logic. Decodes framed host commands and holds per-channel `adder` (phase increment) and `amplitude` words for `NUM_CH` channels plus the global `signalNumber`. Answers reads, samples the live `signal` word and ACK/NAKs every frame.

---
 rtl/uart_param_regs.sv | 320 ++++++++++++++++++++++++++++++++
 tb/tb_uart_param_regs.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_param_regs.sv
// uart_param_regs: framed byte-stream command parser and parameter register bank
// for the waveform generator (per-channel adder/amplitude words, signalNumber).
//
// Frame : A5, cmd {op[1:0], sel, ch[4:0]}, payload (writes, DATA_W/8 bytes MSB
//         first), optional XOR checksum byte.
// Ops   : 00 select, 01 write, 10 read, 11 sample live signal.
//
// Ports : clk, reset (async, active-low)
//         from_uart_data/valid/error/ready - received byte stream
//         to_uart_data/valid/ready         - response byte stream
//         signalNumber                     - selected waveform index
//         adder, amplitude                 - packed NUM_CH x DATA_W registers
//         signal                           - live sample, latched on sample op
//
// Build option: define UART_PARAM_CHECKSUM_EN to add a trailing XOR byte to
// every received frame and every response.
module uart_param_regs #(
    parameter int NUM_CH      = 4,
    parameter int DATA_W      = 32,
    parameter int TIMEOUT_CYC = 50_000_000
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [7:0]               from_uart_data,
    input  logic                     from_uart_valid,
    input  logic                     from_uart_error,
    output logic                     from_uart_ready,
    output logic [7:0]               to_uart_data,
    output logic                     to_uart_valid,
    input  logic                     to_uart_ready,
    output logic [7:0]               signalNumber,
    output logic [NUM_CH*DATA_W-1:0] adder,
    output logic [NUM_CH*DATA_W-1:0] amplitude,
    input  logic [DATA_W-1:0]        signal
);

    localparam int NB = DATA_W / 8;
`ifdef UART_PARAM_CHECKSUM_EN
    localparam int CSB = 1;
`else
    localparam int CSB = 0;
`endif
    localparam int BW = $clog2(NB + CSB + 1);
    localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    localparam logic [7:0] HDR = 8'hA5;
    localparam logic [7:0] ACK = 8'h06;
    localparam logic [7:0] NAK = 8'h15;

    localparam logic [1:0] OP_SEL = 2'b00;
    localparam logic [1:0] OP_WR  = 2'b01;
    localparam logic [1:0] OP_SMP = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD,
        S_PAYLOAD,
`ifdef UART_PARAM_CHECKSUM_EN
        S_CSUM,
`endif
        S_EXEC,
        S_RESP
    } state_t;

    // State that follows the last command/payload byte.
`ifdef UART_PARAM_CHECKSUM_EN
    localparam state_t S_TAIL = S_CSUM;
`else
    localparam state_t S_TAIL = S_EXEC;
`endif

    state_t state_q;
    state_t state_d;

    logic                     rx_en;
    logic                     accept;
    logic                     rx_ok;
    logic                     in_frame;
    logic                     tmo;
    logic                     tx_done;
    logic [7:0]               cmd_q;
    logic [DATA_W-1:0]        pay_q;
    logic [DATA_W-1:0]        tx_shift;
    logic [DATA_W-1:0]        rd_word;
    logic [BW-1:0]            bcnt;
    logic [BW-1:0]            tx_left;
    logic [TW-1:0]            tcnt;
    logic [NUM_CH*DATA_W-1:0] adder_q;
    logic [NUM_CH*DATA_W-1:0] amp_q;
    logic [7:0]               sn_q;
    logic [7:0]               tx_data_q;
    logic                     tx_valid_q;
    logic [1:0]               op;
    logic                     sel;
    logic [4:0]               ch;
    logic                     ch_ok;
    logic                     chk_ok;
    logic                     exec_ok;
`ifdef UART_PARAM_CHECKSUM_EN
    logic [7:0]               csum_q;
    logic                     csum_ok;
    logic [7:0]               tx_xor;
`endif

    assign op  = cmd_q[7:6];
    assign sel = cmd_q[5];
    assign ch  = cmd_q[4:0];

    assign ch_ok = int'(ch) < NUM_CH;
`ifdef UART_PARAM_CHECKSUM_EN
    assign chk_ok = csum_ok;
`else
    assign chk_ok = 1'b1;
`endif
    // Select carries its index in the ch field, so no range check there.
    assign exec_ok = chk_ok && (op == OP_SEL || ch_ok);

`ifdef UART_PARAM_CHECKSUM_EN
    assign in_frame = (state_q == S_CMD) || (state_q == S_PAYLOAD) ||
                      (state_q == S_CSUM);
`else
    assign in_frame = (state_q == S_CMD) || (state_q == S_PAYLOAD);
`endif

    // rx_en keeps ready low until the first clock after reset release.
    assign from_uart_ready = rx_en && (state_q == S_IDLE || in_frame);
    assign accept          = from_uart_valid && from_uart_ready;
    assign rx_ok           = accept && !from_uart_error;
    assign tmo             = in_frame && !accept &&
                             (tcnt == TW'(TIMEOUT_CYC - 1));
    assign tx_done         = tx_valid_q && to_uart_ready && (tx_left == '0);

    assign adder        = adder_q;
    assign amplitude    = amp_q;
    assign signalNumber = sn_q;
    assign to_uart_data = tx_data_q;
    assign to_uart_valid = tx_valid_q;

    always_comb begin
        rd_word = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (ch == 5'(k)) begin
                rd_word = sel ? amp_q[k*DATA_W +: DATA_W]
                              : adder_q[k*DATA_W +: DATA_W];
            end
        end
        if (op == OP_SMP) begin
            rd_word = signal;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (rx_ok && from_uart_data == HDR) begin
                    state_d = S_CMD;
                end
            end
            S_CMD: begin
                if (accept) begin
                    if (from_uart_error) begin
                        state_d = S_IDLE;
                    end else if (from_uart_data[7:6] == OP_WR) begin
                        state_d = S_PAYLOAD;
                    end else begin
                        state_d = S_TAIL;
                    end
                end else if (tmo) begin
                    state_d = S_IDLE;
                end
            end
            S_PAYLOAD: begin
                if (accept) begin
                    if (from_uart_error) begin
                        state_d = S_IDLE;
                    end else if (bcnt == BW'(NB - 1)) begin
                        state_d = S_TAIL;
                    end
                end else if (tmo) begin
                    state_d = S_IDLE;
                end
            end
`ifdef UART_PARAM_CHECKSUM_EN
            S_CSUM: begin
                if (accept) begin
                    state_d = from_uart_error ? S_IDLE : S_EXEC;
                end else if (tmo) begin
                    state_d = S_IDLE;
                end
            end
`endif
            S_EXEC: begin
                state_d = S_RESP;
            end
            S_RESP: begin
                if (tx_done) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_en      <= 1'b0;
            cmd_q      <= '0;
            pay_q      <= '0;
            bcnt       <= '0;
            tcnt       <= '0;
            adder_q    <= '0;
            amp_q      <= '0;
            sn_q       <= '0;
            tx_data_q  <= '0;
            tx_valid_q <= 1'b0;
            tx_shift   <= '0;
            tx_left    <= '0;
`ifdef UART_PARAM_CHECKSUM_EN
            csum_q     <= '0;
            csum_ok    <= 1'b0;
            tx_xor     <= '0;
`endif
        end else begin
            rx_en <= 1'b1;

            // Inter-byte idle counter, restarted by every accepted byte.
            if (!in_frame || accept || tmo) begin
                tcnt <= '0;
            end else begin
                tcnt <= tcnt + TW'(1);
            end

            unique case (state_q)
                S_CMD: begin
                    if (rx_ok) begin
                        cmd_q <= from_uart_data;
                        bcnt  <= '0;
`ifdef UART_PARAM_CHECKSUM_EN
                        csum_q <= from_uart_data;
`endif
                    end
                end
                S_PAYLOAD: begin
                    if (rx_ok) begin
                        pay_q <= (pay_q << 8) | DATA_W'(from_uart_data);
                        bcnt  <= bcnt + BW'(1);
`ifdef UART_PARAM_CHECKSUM_EN
                        csum_q <= csum_q ^ from_uart_data;
`endif
                    end
                end
`ifdef UART_PARAM_CHECKSUM_EN
                S_CSUM: begin
                    if (rx_ok) begin
                        csum_ok <= (from_uart_data == csum_q);
                    end
                end
`endif
                S_EXEC: begin
                    if (exec_ok && op == OP_SEL) begin
                        sn_q <= {3'b0, ch};
                    end
                    for (int k = 0; k < NUM_CH; k++) begin
                        if (exec_ok && op == OP_WR && ch == 5'(k)) begin
                            if (sel) begin
                                amp_q[k*DATA_W +: DATA_W] <= pay_q;
                            end else begin
                                adder_q[k*DATA_W +: DATA_W] <= pay_q;
                            end
                        end
                    end
                    tx_shift   <= rd_word;
                    tx_valid_q <= 1'b1;
                    tx_data_q  <= exec_ok ? ACK : NAK;
                    // Bytes still to send after the ACK/NAK.
                    tx_left    <= (exec_ok && op[1]) ? BW'(NB + CSB)
                                                     : BW'(CSB);
`ifdef UART_PARAM_CHECKSUM_EN
                    tx_xor     <= exec_ok ? ACK : NAK;
`endif
                end
                S_RESP: begin
                    if (tx_valid_q && to_uart_ready) begin
                        if (tx_left == '0) begin
                            tx_valid_q <= 1'b0;
                        end else begin
                            tx_left <= tx_left - BW'(1);
`ifdef UART_PARAM_CHECKSUM_EN
                            if (tx_left == BW'(1)) begin
                                tx_data_q <= tx_xor;
                            end else begin
                                tx_data_q <= tx_shift[DATA_W-1 -: 8];
                                tx_xor    <= tx_xor ^ tx_shift[DATA_W-1 -: 8];
                                tx_shift  <= tx_shift << 8;
                            end
`else
                            tx_data_q <= tx_shift[DATA_W-1 -: 8];
                            tx_shift  <= tx_shift << 8;
`endif
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_param_regs.sv
// tb_uart_param_regs: directed bench for uart_param_regs (checksum macro off),
// NUM_CH=4, DATA_W=32, TIMEOUT_CYC=100.
module tb_uart_param_regs;

    localparam int NUM_CH      = 4;
    localparam int DATA_W      = 32;
    localparam int TIMEOUT_CYC = 100;

    localparam logic [127:0] ADDER_EXP = {64'h0, 32'h12345678, 32'h0};
    localparam logic [127:0] AMP_EXP   = {32'hA5A50001, 96'h0};

    logic                     clk = 1'b0;
    logic                     reset = 1'b0;
    logic [7:0]               from_uart_data = '0;
    logic                     from_uart_valid = 1'b0;
    logic                     from_uart_error = 1'b0;
    logic                     from_uart_ready;
    logic [7:0]               to_uart_data;
    logic                     to_uart_valid;
    logic                     to_uart_ready = 1'b1;
    logic [7:0]               signalNumber;
    logic [NUM_CH*DATA_W-1:0] adder;
    logic [NUM_CH*DATA_W-1:0] amplitude;
    logic [DATA_W-1:0]        signal = '0;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] got[$];

    uart_param_regs #(
        .NUM_CH      (NUM_CH),
        .DATA_W      (DATA_W),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .from_uart_data  (from_uart_data),
        .from_uart_valid (from_uart_valid),
        .from_uart_error (from_uart_error),
        .from_uart_ready (from_uart_ready),
        .to_uart_data    (to_uart_data),
        .to_uart_valid   (to_uart_valid),
        .to_uart_ready   (to_uart_ready),
        .signalNumber    (signalNumber),
        .adder           (adder),
        .amplitude       (amplitude),
        .signal          (signal)
    );

    always #5 clk = ~clk;

    // Bytes handshaken on the coming rising edge.
    always @(negedge clk) begin
        if (to_uart_valid && to_uart_ready) begin
            got.push_back(to_uart_data);
        end
    end

    task automatic check(input string tag, input logic [127:0] obs,
                         input logic [127:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic err);
        int n = 0;
        from_uart_data  = b;
        from_uart_valid = 1'b1;
        from_uart_error = err;
        while (!from_uart_ready && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("rx_ready", from_uart_ready, 1'b1);
        @(posedge clk);
        #1;
        from_uart_valid = 1'b0;
        from_uart_error = 1'b0;
    endtask

    task automatic send_frame(input int n, input logic [47:0] f);
        for (int i = 0; i < n; i++) begin
            send_byte(f[8*(n-1-i) +: 8], 1'b0);
        end
    endtask

    task automatic resp_is(input string tag, input int n,
                           input logic [39:0] exp);
        int k = 0;
        while (got.size() < n && k < 400) begin
            @(posedge clk);
            #1;
            k++;
        end
        repeat (8) @(posedge clk);
        #1;
        check({tag, "_len"}, got.size(), n);
        for (int i = 0; i < n && i < got.size(); i++) begin
            check($sformatf("%s_b%0d", tag, i), got[i], exp[8*(n-1-i) +: 8]);
        end
        got.delete();
    endtask

    initial begin
        logic [7:0] bp_data;
        logic       stable;
        int         k;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", from_uart_ready, 1'b0);
        check("rst_valid", to_uart_valid, 1'b0);
        check("rst_data", to_uart_data, 8'h00);
        check("rst_sn", signalNumber, 8'h00);
        check("rst_adder", adder, '0);
        check("rst_amp", amplitude, '0);
        reset = 1'b1;
        #1;
        check("rel_pre", from_uart_ready, 1'b0);
        @(posedge clk);
        #1;
        check("rel_ready", from_uart_ready, 1'b1);

        // Write adder[1], check commit edge and ACK latency
        send_frame(6, 48'hA541_12345678);
        check("wr_pre", adder[63:32], 32'h0);
        @(posedge clk);
        #1;
        check("wr_vis", adder, ADDER_EXP);
        check("ack_lat", to_uart_valid, 1'b1);
        resp_is("wr", 1, 40'h06);
        check("wr_amp", amplitude, '0);

        send_frame(2, 48'hA581);
        resp_is("rd_add1", 5, 40'h06_12345678);

        // Top channel, payload containing header bytes
        send_frame(6, 48'hA563_A5A50001);
        resp_is("wr_amp3", 1, 40'h06);
        check("amp3", amplitude, AMP_EXP);
        send_frame(2, 48'hA5A3);
        resp_is("rd_amp3", 5, 40'h06_A5A50001);
        send_frame(2, 48'hA5A1);
        resp_is("rd_amp1", 5, 40'h06_00000000);

        // Out-of-range channels
        send_frame(6, 48'hA547_DEADBEEF);
        resp_is("badch", 1, 40'h15);
        check("badch_add", adder, ADDER_EXP);
        check("badch_amp", amplitude, AMP_EXP);
        send_frame(2, 48'hA584);
        resp_is("rd_ch4", 1, 40'h15);

        signal = 32'hCAFEF00D;
        send_frame(2, 48'hA5C0);
        resp_is("sample", 5, 40'h06_CAFEF00D);

        send_frame(2, 48'hA51F);
        resp_is("sel1f", 1, 40'h06);
        check("sn_1f", signalNumber, 8'h1F);

        // Timeout drops partial frame
        send_frame(3, 48'hA54112);
        repeat (110) @(posedge clk);
        #1;
        send_frame(2, 48'hA502);
        resp_is("tmo", 1, 40'h06);
        check("tmo_sn", signalNumber, 8'h02);
        check("tmo_add", adder, ADDER_EXP);

        // Error flag on payload byte
        send_frame(3, 48'hA54112);
        send_byte(8'h34, 1'b1);
        resp_is("err", 0, 40'h0);
        send_frame(2, 48'hA503);
        resp_is("err_next", 1, 40'h06);
        check("err_sn", signalNumber, 8'h03);
        check("err_add", adder, ADDER_EXP);

        // Backpressure on a read response
        to_uart_ready = 1'b0;
        send_frame(2, 48'hA581);
        k = 0;
        while (!to_uart_valid && k < 50) begin
            @(posedge clk);
            #1;
            k++;
        end
        bp_data = to_uart_data;
        stable = 1'b1;
        repeat (20) begin
            @(posedge clk);
            #1;
            if (!to_uart_valid || to_uart_data !== bp_data) stable = 1'b0;
        end
        check("bp_first", bp_data, 8'h06);
        check("bp_stable", stable, 1'b1);
        to_uart_ready = 1'b1;
        resp_is("bp", 5, 40'h06_12345678);

        // Reset in the middle of a response
        to_uart_ready = 1'b0;
        send_frame(2, 48'hA581);
        k = 0;
        while (!to_uart_valid && k < 50) begin
            @(posedge clk);
            #1;
            k++;
        end
        check("mid_valid", to_uart_valid, 1'b1);
        reset = 1'b0;
        #1;
        check("mid_txv", to_uart_valid, 1'b0);
        check("mid_txd", to_uart_data, 8'h00);
        check("mid_rdy", from_uart_ready, 1'b0);
        check("mid_sn", signalNumber, 8'h00);
        check("mid_add", adder, '0);
        check("mid_amp", amplitude, '0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        got.delete();
        to_uart_ready = 1'b1;
        @(posedge clk);
        #1;
        check("mid_rel", from_uart_ready, 1'b1);
        send_frame(2, 48'hA502);
        resp_is("post_rst", 1, 40'h06);
        check("post_sn", signalNumber, 8'h02);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
